// File: rtl/register_writer.sv
// Write-back stage: formats the result leaving the memory stage and drives the regfile write port.
// Ports: clk, rst_n (sync, active-low), in_* instruction fields, reg_wr_* write port, load_fault, instret.
module register_writer #(
  parameter int CNT_W = 64
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_noop,
  input  logic [6:0]       in_opcode,
  input  logic [2:0]       in_funct3,
  input  logic [4:0]       in_rd,
  input  logic [31:0]      in_imm,
  input  logic [31:0]      in_res,
  input  logic [31:0]      in_mem_rd,
  input  logic [1:0]       in_addr_lo,
  output logic             reg_wr_en,
  output logic [4:0]       reg_wr_addr,
  output logic [31:0]      reg_wr_data,
  output logic             load_fault,
  output logic [CNT_W-1:0] instret
);

  localparam logic [6:0] OP_LUI   = 7'b0110111;
  localparam logic [6:0] OP_REG   = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_AUIPC = 7'b0010111;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_data;
  logic        ld_rsvd;
  logic [31:0] wdata;
  logic        writes;
  logic        fault;

  // byte lane from both address bits, half lane from bit 1 only
  assign ld_byte = in_mem_rd[{in_addr_lo, 3'b000} +: 8];
  assign ld_half = in_mem_rd[{in_addr_lo[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = in_mem_rd;
    ld_rsvd = 1'b0;
    case (in_funct3)
      3'b000:  ld_data = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_data = {{16{ld_half[15]}}, ld_half};
      3'b010:  ld_data = in_mem_rd;
      3'b100:  ld_data = {24'd0, ld_byte};
      3'b101:  ld_data = {16'd0, ld_half};
      default: ld_rsvd = 1'b1;
    endcase
  end

  always_comb begin
    wdata  = in_res;
    writes = 1'b0;
    fault  = 1'b0;
    case (in_opcode)
      OP_LUI: begin
        wdata  = in_imm;
        writes = 1'b1;
      end
      OP_REG, OP_IMM, OP_JAL, OP_JALR, OP_AUIPC: begin
        wdata  = in_res;
        writes = 1'b1;
      end
      OP_LOAD: begin
        wdata  = ld_data;
        writes = 1'b1;
        fault  = ld_rsvd;
      end
      default: begin
        wdata  = in_res;
        writes = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      reg_wr_en   <= 1'b0;
      reg_wr_addr <= '0;
      reg_wr_data <= '0;
      load_fault  <= 1'b0;
      instret     <= '0;
    end else if (in_noop) begin
      // bubble: address/data keep last values
      reg_wr_en  <= 1'b0;
      load_fault <= 1'b0;
    end else begin
      reg_wr_en   <= writes && (in_rd != 5'd0);
      reg_wr_addr <= in_rd;
      reg_wr_data <= wdata;
      load_fault  <= fault;
      instret     <= instret + 1'b1;
    end
  end

endmodule

// File: tb/tb_register_writer.sv
// Self-checking bench for register_writer: directed steps then random stream vs a reference model.
// Two instances share stimulus: default 64-bit counter and a 4-bit counter for wrap checks.
module tb_register_writer;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_noop;
  logic [6:0]  in_opcode;
  logic [2:0]  in_funct3;
  logic [4:0]  in_rd;
  logic [31:0] in_imm;
  logic [31:0] in_res;
  logic [31:0] in_mem_rd;
  logic [1:0]  in_addr_lo;

  logic        reg_wr_en, reg_wr_en4;
  logic [4:0]  reg_wr_addr, reg_wr_addr4;
  logic [31:0] reg_wr_data, reg_wr_data4;
  logic        load_fault, load_fault4;
  logic [63:0] instret;
  logic [3:0]  instret4;

  always #5 clk = ~clk;

  register_writer dut (
    .clk(clk), .rst_n(rst_n), .in_noop(in_noop),
    .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_imm(in_imm), .in_res(in_res),
    .in_mem_rd(in_mem_rd), .in_addr_lo(in_addr_lo),
    .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr),
    .reg_wr_data(reg_wr_data), .load_fault(load_fault),
    .instret(instret)
  );

  register_writer #(.CNT_W(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .in_noop(in_noop),
    .in_opcode(in_opcode), .in_funct3(in_funct3),
    .in_rd(in_rd), .in_imm(in_imm), .in_res(in_res),
    .in_mem_rd(in_mem_rd), .in_addr_lo(in_addr_lo),
    .reg_wr_en(reg_wr_en4), .reg_wr_addr(reg_wr_addr4),
    .reg_wr_data(reg_wr_data4), .load_fault(load_fault4),
    .instret(instret4)
  );

  localparam logic [6:0] LUI = 7'b0110111, OPR = 7'b0110011;
  localparam logic [6:0] OPI = 7'b0010011, JAL = 7'b1101111;
  localparam logic [6:0] JALR = 7'b1100111, AUIPC = 7'b0010111;
  localparam logic [6:0] LOAD = 7'b0000011, STORE = 7'b0100011;
  localparam logic [6:0] BRANCH = 7'b1100011, SYS = 7'b1110011;

  int passed = 0;
  int total = 0;

  logic        m_en, m_fault;
  logic [4:0]  m_addr;
  logic [31:0] m_data;
  bit          m_dvalid;
  longint unsigned m_cnt;
  int          m_cnt4;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  function automatic logic [31:0] ld_ref(int f3, int unsigned mem, int lo);
    int unsigned b, h;
    b = (mem >> (8 * lo)) % 256;
    h = (mem >> (16 * (lo / 2))) % 65536;
    case (f3)
      0: return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      1: return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      4: return b;
      5: return h;
      default: return mem;
    endcase
  endfunction

  task automatic model();
    bit wr;
    if (!rst_n) begin
      m_en = 0; m_fault = 0; m_addr = 0; m_data = 0;
      m_dvalid = 1; m_cnt = 0; m_cnt4 = 0;
    end else if (in_noop) begin
      m_en = 0; m_fault = 0;
    end else begin
      m_cnt++;
      m_cnt4 = (m_cnt4 + 1) % 16;
      wr = 1;
      m_fault = 0;
      if (in_opcode == LUI) m_data = in_imm;
      else if (in_opcode inside {OPR, OPI, JAL, JALR, AUIPC})
        m_data = in_res;
      else if (in_opcode == LOAD) begin
        m_data = ld_ref(int'(in_funct3), in_mem_rd, int'(in_addr_lo));
        m_fault = in_funct3 inside {3'd3, 3'd6, 3'd7};
      end else wr = 0;
      m_dvalid = wr;
      m_addr = in_rd;
      m_en = wr && (in_rd != 0);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model();
    #1;
    chk("wr_en", 64'(reg_wr_en), 64'(m_en));
    chk("fault", 64'(load_fault), 64'(m_fault));
    chk("addr", 64'(reg_wr_addr), 64'(m_addr));
    if (m_dvalid) chk("data", 64'(reg_wr_data), 64'(m_data));
    chk("instret", instret, m_cnt);
    chk("instret4", 64'(instret4), 64'(m_cnt4));
  endtask

  task automatic drive(bit noop, logic [6:0] op, logic [2:0] f3,
                       logic [4:0] rd, logic [31:0] imm,
                       logic [31:0] res, logic [31:0] mem,
                       logic [1:0] lo);
    in_noop = noop; in_opcode = op; in_funct3 = f3; in_rd = rd;
    in_imm = imm; in_res = res; in_mem_rd = mem; in_addr_lo = lo;
  endtask

  logic [6:0] ops [10];
  localparam logic [31:0] MW = 32'h80F1_7F82;

  initial begin
    ops = '{LUI, OPR, OPI, JAL, JALR, AUIPC, LOAD, STORE, BRANCH, SYS};
    m_en = 0; m_fault = 0; m_addr = 0; m_data = 0;
    m_dvalid = 0; m_cnt = 0; m_cnt4 = 0;

    // reset held two cycles with a valid instruction present
    rst_n = 0;
    drive(0, OPI, 0, 7, 32'h1, 32'h55, MW, 0);
    @(negedge clk);
    tick();
    tick();
    chk("rst_en", 64'(reg_wr_en), 0);
    chk("rst_data", 64'(reg_wr_data), 0);
    chk("rst_instret", instret, 0);
    rst_n = 1;

    drive(0, OPI, 0, 5, 0, 32'h0000_1234, 0, 0);
    tick();
    chk("addi_en", 64'(reg_wr_en), 1);
    chk("addi_data", 64'(reg_wr_data), 32'h1234);
    chk("first_instret", instret, 1);

    drive(0, LUI, 0, 0, 32'hABCD_E000, 0, 0, 0);
    tick();
    chk("lui_rd0_en", 64'(reg_wr_en), 0);
    chk("lui_rd0_cnt", instret, 2);

    drive(1, OPI, 0, 9, 0, 32'h77, 0, 0);
    tick();
    chk("noop_cnt", instret, 2);

    drive(0, LOAD, 3'b000, 1, 0, 0, MW, 0);
    tick();
    chk("lb", 64'(reg_wr_data), 32'hFFFF_FF82);
    drive(0, LOAD, 3'b100, 2, 0, 0, MW, 1);
    tick();
    chk("lbu", 64'(reg_wr_data), 32'h0000_007F);
    drive(0, LOAD, 3'b001, 3, 0, 0, MW, 2);
    tick();
    chk("lh", 64'(reg_wr_data), 32'hFFFF_80F1);
    drive(0, LOAD, 3'b101, 4, 0, 0, MW, 3);
    tick();
    chk("lhu", 64'(reg_wr_data), 32'h0000_80F1);
    drive(0, LOAD, 3'b010, 6, 0, 0, MW, 1);
    tick();
    chk("lw", 64'(reg_wr_data), MW);

    drive(0, LOAD, 3'b110, 8, 0, 0, MW, 2);
    tick();
    chk("rsvd_data", 64'(reg_wr_data), MW);
    chk("rsvd_fault", 64'(load_fault), 1);
    drive(0, STORE, 3'b010, 10, 0, 0, MW, 0);
    tick();
    chk("sw_fault_drop", 64'(load_fault), 0);
    chk("sw_en", 64'(reg_wr_en), 0);
    chk("sw_cnt", instret, 9);

    // 4-bit counter wrap from reset
    rst_n = 0;
    tick();
    rst_n = 1;
    for (int i = 0; i < 16; i++) begin
      drive(0, ops[$urandom_range(9)], 3'($urandom),
            5'($urandom), $urandom, $urandom, $urandom,
            2'($urandom));
      tick();
      if (i == 14) chk("wrap_15", 64'(instret4), 15);
      if (i == 15) chk("wrap_0", 64'(instret4), 0);
    end
    for (int i = 0; i < 3; i++) begin
      drive(0, OPR, 0, 5'(i + 1), 0, $urandom, 0, 0);
      tick();
    end
    rst_n = 0;
    tick();
    chk("midrst_4", 64'(instret4), 0);
    chk("midrst_64", instret, 0);
    rst_n = 1;

    // random stream
    for (int i = 0; i < 300; i++) begin
      logic [6:0] op;
      op = ($urandom_range(15) == 0) ? 7'($urandom)
                                     : ops[$urandom_range(9)];
      drive($urandom_range(4) == 0, op, 3'($urandom),
            ($urandom_range(7) == 0) ? 5'd0 : 5'($urandom),
            $urandom, $urandom, $urandom, 2'($urandom));
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
